frame_check_sequence_checker: RTL and testbench
===============================================

Name: frame_check_sequence_checker

Overview:
Receive-side counterpart of frame_check_sequence_generator. It takes an Ethernet frame as an 8-bit byte stream that ends with its 4-byte FCS, and runs CRC-32 over the whole frame including the FCS. It strips the FCS and forwards the payload bytes delayed by 4 bytes. At end of frame it reports good/bad status and the payload length. It sits between the RX byte assembler and the switch ingress buffer.

Parameters:
MIN_FRAME_BYTES, 64, minimum total frame length in bytes (FCS included); shorter frames flag length_error.
LENGTH_WIDTH, 16, width of frame_length; the count saturates at all-ones.

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
s_data  input  8  received byte
s_valid  input  1  s_data valid this cycle; gaps allowed mid-frame
s_last  input  1  qualifies the final byte of the frame (last FCS byte)
s_error  input  1  PHY error on this byte; sampled only when s_valid=1
m_data  output  8  payload byte
m_valid  output  1  m_data valid
m_last  output  1  final payload byte
frame_done  output  1  one-cycle end-of-frame status strobe
fcs_ok  output  1  residue matched; valid only when frame_done=1
length_error  output  1  total bytes < MIN_FRAME_BYTES or total < 5; valid with frame_done
phy_error  output  1  any s_error seen in frame; valid with frame_done
frame_length  output  LENGTH_WIDTH  payload byte count (total minus 4); valid with frame_done

Behaviour:
- Reset is synchronous (reset_n=0 at a clock edge). All outputs reset to 0. CRC register resets to 0xFFFFFFFF. Byte counter and delay line are cleared. State goes to IDLE.
- CRC-32 uses reflected polynomial 0xEDB88320, processes LSB first, starts from 0xFFFFFFFF, with no final XOR. It updates one byte per accepted byte.
- A frame is good when the register equals 0xDEBB20E3 after the s_last byte is processed.
- Delay line: 4-entry byte shift register plus fill count 0..4.
- State machine:
  - IDLE: waits for s_valid.
  - FILL: fewer than 4 bytes held.
  - STREAM: 4 bytes held.
  - The first valid byte moves IDLE→FILL (or IDLE→STREAM path if already 4; not possible on the first byte).
  - The 4th held byte moves FILL→STREAM.
  - s_last in any state emits status and returns to IDLE. The CRC and counters are reinitialised for the next frame on that same edge.
- STREAM byte handling: when a byte is accepted with fill=4, the oldest byte appears on m_data with m_valid=1 on the following cycle. So payload byte k appears 1 cycle after input byte k+4 is accepted.
- No backpressure. m_valid is a 1-cycle pulse per emitted byte, and is 0 in cycles without an accepted byte.
- m_last=1 accompanies the payload byte emitted because of the s_last byte. frame_done is asserted on that same cycle, i.e. 1 cycle after s_last is accepted.
- Runt frames (total ≤ 4 bytes): no m_valid ever. frame_done=1 with fcs_ok=0 and length_error=1, 1 cycle after s_last.
- frame_length = total accepted bytes − 4, counted in LENGTH_WIDTH bits and saturating. It is 0 for runts.
- phy_error is sticky within a frame and cleared at frame start. It does not alter fcs_ok.
- s_last=1 together with s_valid=1 on the very first byte is a 1-byte runt, handled as above.
- If s_valid=1 arrives on the cycle immediately after s_last, it starts a new frame with no idle cycle needed. Its CRC starts from 0xFFFFFFFF.
- Reset mid-frame drops the partial frame. No frame_done and no further m_valid are produced for it. The next accepted byte is treated as byte 0 of a new frame.
- s_data, s_last and s_error are ignored when s_valid=0.

Test Plan:
- Good frame, MIN_FRAME_BYTES=13: send ASCII "123456789" (0x31..0x39) then 0x26,0x39,0xF4,0xCB with s_last on 0xCB.
  - Required response: 9 m_valid bytes 0x31..0x39, m_last on 0x39.
  - frame_done with fcs_ok=1, length_error=0, frame_length=9.
- Same frame with the last FCS byte changed to 0xCA → same 9 payload bytes, frame_done with fcs_ok=0.
- Same good frame with MIN_FRAME_BYTES=64 → fcs_ok=1, length_error=1, frame_length=9.
- Runt: 3 bytes with s_last on the 3rd → no m_valid; frame_done with fcs_ok=0, length_error=1, frame_length=0.
- Gapped input plus back-to-back frames:
  - Drive the good frame with random s_valid gaps, then a second good frame starting the cycle after s_last.
  - Required response: each payload byte appears 1 cycle after the input byte 4 positions later; two frame_done pulses, both fcs_ok=1.
  - Also assert s_error on byte 2 of the second frame → phy_error=1 on the second status only.
- Reset mid-frame: after 6 bytes, pulse reset_n=0 for 1 cycle, then send the good frame.
  - Required response: no status for the aborted frame; the good frame reports fcs_ok=1 and frame_length=9.

Source files
------------

// File: rtl/frame_check_sequence_checker.sv
// Receive-side CRC-32 FCS checker. It strips the trailing 4-byte FCS through a 4-byte delay line
// and reports good/bad status and the payload length at end of frame.
module frame_check_sequence_checker #(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned LENGTH_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic                    s_error,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    frame_done,
  output logic                    fcs_ok,
  output logic                    length_error,
  output logic                    phy_error,
  output logic [LENGTH_WIDTH-1:0] frame_length
);

  // One spare bit lets the payload length saturate cleanly after the FCS is subtracted.
  localparam int unsigned CntW    = LENGTH_WIDTH + 1;
  localparam logic [31:0] Poly    = 32'hEDB88320;
  localparam logic [31:0] Residue = 32'hDEBB20E3;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ Poly) : (c >> 1);
    end
    return c;
  endfunction

  state_e                  state_q, state_d;
  logic [31:0]             crc_q, crc_d;
  logic [CntW-1:0]         total_q, total_d;
  logic [2:0]              fill_q, fill_d;
  logic [3:0][7:0]         dly_q, dly_d;
  logic                    phy_q, phy_d;

  logic [7:0]              m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    frame_done_q, frame_done_d;
  logic                    fcs_ok_q, fcs_ok_d;
  logic                    length_error_q, length_error_d;
  logic                    phy_error_q, phy_error_d;
  logic [LENGTH_WIDTH-1:0] frame_length_q, frame_length_d;

  logic [31:0]             crc_nxt;
  logic [CntW-1:0]         total_nxt;
  logic [CntW-1:0]         payload;
  logic                    phy_nxt;

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    total_d        = total_q;
    fill_d         = fill_q;
    dly_d          = dly_q;
    phy_d          = phy_q;
    m_data_d       = m_data_q;
    m_valid_d      = 1'b0;
    m_last_d       = 1'b0;
    frame_done_d   = 1'b0;
    fcs_ok_d       = 1'b0;
    length_error_d = 1'b0;
    phy_error_d    = 1'b0;
    frame_length_d = '0;

    crc_nxt   = crc32_byte(crc_q, s_data);
    total_nxt = (&total_q) ? total_q : total_q + CntW'(1);
    payload   = total_nxt - CntW'(4);
    phy_nxt   = phy_q | s_error;

    if (s_valid) begin
      crc_d   = crc_nxt;
      total_d = total_nxt;
      phy_d   = phy_nxt;
      dly_d   = {dly_q[2:0], s_data};

      if (state_q == StStream) begin
        m_valid_d = 1'b1;
        m_data_d  = dly_q[3];
      end else begin
        fill_d = fill_q + 3'd1;
      end

      unique case (state_q)
        StIdle:   state_d = StFill;
        StFill:   if (fill_q == 3'd3) state_d = StStream;
        StStream: state_d = StStream;
        default:  state_d = StIdle;
      endcase

      if (s_last) begin
        frame_done_d   = 1'b1;
        m_last_d       = (state_q == StStream);
        fcs_ok_d       = (crc_nxt == Residue) && (total_nxt >= CntW'(5));
        length_error_d = (total_nxt < CntW'(MIN_FRAME_BYTES)) || (total_nxt < CntW'(5));
        phy_error_d    = phy_nxt;
        if (total_nxt < CntW'(4)) begin
          frame_length_d = '0;
        end else if (payload[CntW-1]) begin
          frame_length_d = '1;
        end else begin
          frame_length_d = payload[LENGTH_WIDTH-1:0];
        end
        // Next frame may start on the very next cycle, so rearm everything here.
        state_d = StIdle;
        crc_d   = CrcInit;
        total_d = '0;
        fill_d  = '0;
        phy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      crc_q          <= CrcInit;
      total_q        <= '0;
      fill_q         <= '0;
      dly_q          <= '0;
      phy_q          <= 1'b0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      fcs_ok_q       <= 1'b0;
      length_error_q <= 1'b0;
      phy_error_q    <= 1'b0;
      frame_length_q <= '0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      total_q        <= total_d;
      fill_q         <= fill_d;
      dly_q          <= dly_d;
      phy_q          <= phy_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_last_q       <= m_last_d;
      frame_done_q   <= frame_done_d;
      fcs_ok_q       <= fcs_ok_d;
      length_error_q <= length_error_d;
      phy_error_q    <= phy_error_d;
      frame_length_q <= frame_length_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign frame_done   = frame_done_q;
  assign fcs_ok       = fcs_ok_q;
  assign length_error = length_error_q;
  assign phy_error    = phy_error_q;
  assign frame_length = frame_length_q;

endmodule

// File: tb/tb_frame_check_sequence_checker.sv
// Bench for frame_check_sequence_checker: two instances (min length 13 and 64) share one stimulus
// stream; expected payload/status events are queued with the cycle they must appear in.
module tb_frame_check_sequence_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_error;

  logic [7:0]  a_m_data, b_m_data;
  logic        a_m_valid, b_m_valid, a_m_last, b_m_last;
  logic        a_frame_done, b_frame_done, a_fcs_ok, b_fcs_ok;
  logic        a_length_error, b_length_error, a_phy_error, b_phy_error;
  logic [15:0] a_frame_length, b_frame_length;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  frame_check_sequence_checker #(.MIN_FRAME_BYTES(13), .LENGTH_WIDTH(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_error(s_error), .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last),
    .frame_done(a_frame_done), .fcs_ok(a_fcs_ok), .length_error(a_length_error),
    .phy_error(a_phy_error), .frame_length(a_frame_length)
  );

  frame_check_sequence_checker #(.MIN_FRAME_BYTES(64), .LENGTH_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_error(s_error), .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last),
    .frame_done(b_frame_done), .fcs_ok(b_fcs_ok), .length_error(b_length_error),
    .phy_error(b_phy_error), .frame_length(b_frame_length)
  );

  typedef struct {
    logic [15:0][7:0] b;
    int               n;
    bit               gaps;
    bit               b2b;
    int               err_idx;
    bit               ok;
    bit               le13;
    bit               le64;
    int               len;
    bit               phy;
  } vec_t;

  typedef struct { logic [7:0] d; bit l; int c; } out_t;
  typedef struct { bit ok; bit le13; bit le64; int len; bit phy; int c; } st_t;

  vec_t vecs[6];
  out_t exp_out[$];
  st_t  exp_st[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    out_t o;
    st_t  s;
    if (a_m_valid || b_m_valid) begin
      checks++;
      if (exp_out.size() == 0) begin
        errors++;
        $display("FAIL payload_spurious cyc=%0d got data=%h/%h expected no output", cyc,
                 a_m_data, b_m_data);
      end else begin
        o = exp_out.pop_front();
        if (!(a_m_valid && b_m_valid && a_m_data == o.d && b_m_data == o.d &&
              a_m_last == o.l && b_m_last == o.l && cyc == o.c)) begin
          errors++;
          $display("FAIL payload got v=%b/%b d=%h/%h last=%b/%b cyc=%0d expected d=%h last=%b cyc=%0d",
                   a_m_valid, b_m_valid, a_m_data, b_m_data, a_m_last, b_m_last, cyc, o.d, o.l, o.c);
        end
      end
    end
    if (a_frame_done || b_frame_done) begin
      checks++;
      if (exp_st.size() == 0) begin
        errors++;
        $display("FAIL status_spurious cyc=%0d got frame_done expected none", cyc);
      end else begin
        s = exp_st.pop_front();
        if (!(a_frame_done && b_frame_done && a_fcs_ok == s.ok && b_fcs_ok == s.ok &&
              a_length_error == s.le13 && b_length_error == s.le64 &&
              a_phy_error == s.phy && b_phy_error == s.phy &&
              a_frame_length == 16'(s.len) && b_frame_length == 16'(s.len) && cyc == s.c)) begin
          errors++;
          $display("FAIL status got ok=%b/%b le=%b/%b phy=%b/%b len=%0d/%0d cyc=%0d expected ok=%b le=%b/%b phy=%b len=%0d cyc=%0d",
                   a_fcs_ok, b_fcs_ok, a_length_error, b_length_error, a_phy_error, b_phy_error,
                   a_frame_length, b_frame_length, cyc, s.ok, s.le13, s.le64, s.phy, s.len, s.c);
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      s_error = 1'($urandom);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit last, input bit err, output int acc);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_error = err;
    @(posedge clock);
    #1;
    acc     = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_error = 1'b0;
  endtask

  task automatic send(input vec_t v, input int n_send);
    int acc;
    bit last;
    for (int k = 0; k < n_send; k++) begin
      if (v.gaps && !(k == 0 && v.b2b)) idle($urandom_range(0, 2));
      last = (k == v.n - 1);
      drive_byte(v.b[k], last, k == v.err_idx, acc);
      if (k >= 4) exp_out.push_back('{d: v.b[k-4], l: last, c: acc});
      if (last) exp_st.push_back('{ok: v.ok, le13: v.le13, le64: v.le64, len: v.len,
                                   phy: v.phy, c: acc});
    end
  endtask

  initial begin
    logic [15:0][7:0] good;
    logic [15:0][7:0] bad;
    good = '0;
    for (int i = 0; i < 9; i++) good[i] = 8'h31 + 8'(i);
    good[9]  = 8'h26;
    good[10] = 8'h39;
    good[11] = 8'hF4;
    good[12] = 8'hCB;
    bad      = good;
    bad[12]  = 8'hCA;

    vecs[0] = '{b: good, n: 13, gaps: 0, b2b: 0, err_idx: -1, ok: 1, le13: 0, le64: 1, len: 9, phy: 0};
    vecs[1] = '{b: bad,  n: 13, gaps: 0, b2b: 0, err_idx: -1, ok: 0, le13: 0, le64: 1, len: 9, phy: 0};
    vecs[2] = '{b: good, n: 3,  gaps: 0, b2b: 0, err_idx: -1, ok: 0, le13: 1, le64: 1, len: 0, phy: 0};
    vecs[3] = '{b: good, n: 1,  gaps: 0, b2b: 0, err_idx: -1, ok: 0, le13: 1, le64: 1, len: 0, phy: 0};
    vecs[4] = '{b: good, n: 13, gaps: 1, b2b: 0, err_idx: -1, ok: 1, le13: 0, le64: 1, len: 9, phy: 0};
    vecs[5] = '{b: good, n: 13, gaps: 1, b2b: 1, err_idx: 2,  ok: 1, le13: 0, le64: 1, len: 9, phy: 1};

    reset_n = 1'b0;
    idle(2);
    @(negedge clock);
    chk("reset_m_valid", 32'(a_m_valid), 0);
    chk("reset_m_data", 32'(a_m_data), 0);
    chk("reset_m_last", 32'(a_m_last), 0);
    chk("reset_frame_done", 32'(a_frame_done), 0);
    chk("reset_fcs_ok", 32'(a_fcs_ok), 0);
    chk("reset_length_error", 32'(a_length_error), 0);
    chk("reset_phy_error", 32'(a_phy_error), 0);
    chk("reset_frame_length", 32'(a_frame_length), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) idle(2);
      send(vecs[i], vecs[i].n);
    end

    // Abort a frame after 6 bytes; its first two payload bytes are already out.
    idle(2);
    send(vecs[0], 6);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midreset_m_valid", 32'(a_m_valid), 0);
    chk("midreset_frame_done", 32'(a_frame_done), 0);
    idle(3);
    send(vecs[0], vecs[0].n);

    idle(8);
    chk("pending_payload", 32'(exp_out.size()), 0);
    chk("pending_status", 32'(exp_st.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
